// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a start/busy/done handshake, an iterative
// shift-add multiplier (unsigned and signed) and ownership of the SREG.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [3:0]           op,
   input  logic                 use_carry,
   input  logic [WIDTH-1:0]     arg1,
   input  logic [WIDTH-1:0]     arg2,
   input  logic                 sreg_write,
   input  logic [7:0]           sreg_wdata,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   result,
   output logic [7:0]           sreg
);

   localparam int M  = WIDTH - 1;
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_MUL  = 4'd2;
   localparam logic [3:0] OP_MULS = 4'd3;
   localparam logic [3:0] OP_LSL  = 4'd4;
   localparam logic [3:0] OP_LSR  = 4'd5;
   localparam logic [3:0] OP_ASR  = 4'd6;
   localparam logic [3:0] OP_AND  = 4'd7;
   localparam logic [3:0] OP_OR   = 4'd8;
   localparam logic [3:0] OP_XOR  = 4'd9;
   localparam logic [3:0] OP_CP   = 4'd10;

   typedef enum logic {IDLE, MUL} state_t;
   state_t state, state_next;

   logic                 accept, is_mul, last_step;
   logic [2*WIDTH-1:0]   acc, mcand, addend, acc_next;
   logic [WIDTH-1:0]     mplier;
   logic [CW-1:0]        count;
   logic                 mul_signed;

   logic                 cin, v, c_out, is_shift, is_logic, keep_result;
   logic [WIDTH:0]       sum, diff;
   logic [WIDTH-1:0]     alu_res;
   logic [7:0]           alu_sreg, mul_sreg;

   assign busy      = (state == MUL);
   assign accept    = (state == IDLE) && start;
   assign is_mul    = (op == OP_MUL) || (op == OP_MULS);
   assign last_step = (state == MUL) && (count == CW'(1));

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept && is_mul) state_next = MUL;
         MUL:     if (last_step) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // For MULS the multiplier MSB has negative weight, so the final partial product is subtracted.
   always_comb begin
      addend      = mplier[0] ? mcand : '0;
      acc_next    = (mul_signed && (count == CW'(1))) ? acc - addend : acc + addend;
      mul_sreg    = sreg;
      mul_sreg[0] = acc_next[2*WIDTH-1];
      mul_sreg[1] = (acc_next == '0);
   end

   always_comb begin
      cin         = use_carry & sreg[0];
      sum         = {1'b0, arg1} + {1'b0, arg2} + {{WIDTH{1'b0}}, cin};
      diff        = {1'b0, arg1} - {1'b0, arg2} - {{WIDTH{1'b0}}, cin};
      alu_res     = '0;
      alu_sreg    = sreg;
      keep_result = 1'b0;
      is_shift    = 1'b0;
      is_logic    = 1'b0;
      c_out       = 1'b0;
      v           = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res     = sum[M:0];
            v           = (arg1[M] & arg2[M] & ~sum[M]) | (~arg1[M] & ~arg2[M] & sum[M]);
            alu_sreg[0] = sum[WIDTH];
            alu_sreg[1] = (sum[M:0] == '0);
            alu_sreg[2] = sum[M];
            alu_sreg[3] = v;
            alu_sreg[4] = sum[M] ^ v;
            alu_sreg[5] = (arg1[3] & arg2[3]) | (arg2[3] & ~sum[3]) | (~sum[3] & arg1[3]);
         end
         OP_SUB, OP_CP: begin
            alu_res     = (op == OP_CP) ? '0 : diff[M:0];
            keep_result = (op == OP_CP);
            v           = (arg1[M] & ~arg2[M] & ~diff[M]) | (~arg1[M] & arg2[M] & diff[M]);
            alu_sreg[0] = diff[WIDTH];
            alu_sreg[1] = (diff[M:0] == '0) & (~use_carry | sreg[1]);
            alu_sreg[2] = diff[M];
            alu_sreg[3] = v;
            alu_sreg[4] = diff[M] ^ v;
            alu_sreg[5] = (~arg1[3] & arg2[3]) | (arg2[3] & diff[3]) | (diff[3] & ~arg1[3]);
         end
         OP_LSL: begin
            alu_res     = {arg1[M-1:0], cin};
            c_out       = arg1[M];
            is_shift    = 1'b1;
            alu_sreg[5] = arg1[3];
         end
         OP_LSR: begin
            alu_res  = {cin, arg1[M:1]};
            c_out    = arg1[0];
            is_shift = 1'b1;
         end
         OP_ASR: begin
            alu_res  = {arg1[M], arg1[M:1]};
            c_out    = arg1[0];
            is_shift = 1'b1;
         end
         OP_AND: begin
            alu_res  = arg1 & arg2;
            is_logic = 1'b1;
         end
         OP_OR: begin
            alu_res  = arg1 | arg2;
            is_logic = 1'b1;
         end
         OP_XOR: begin
            alu_res  = arg1 ^ arg2;
            is_logic = 1'b1;
         end
         default: begin
            alu_res = '0;
         end
      endcase
      if (is_shift) begin
         alu_sreg[0] = c_out;
         alu_sreg[1] = (alu_res == '0);
         alu_sreg[2] = alu_res[M];
         alu_sreg[3] = alu_res[M] ^ c_out;
         alu_sreg[4] = c_out;
      end
      if (is_logic) begin
         alu_sreg[1] = (alu_res == '0);
         alu_sreg[2] = alu_res[M];
         alu_sreg[3] = 1'b0;
         alu_sreg[4] = alu_res[M];
      end
   end

   // Datapath: single-cycle ops finish on the accepting edge; multiplies step once per edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc        <= '0;
         mcand      <= '0;
         mplier     <= '0;
         count      <= '0;
         mul_signed <= 1'b0;
         result     <= '0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            if (is_mul) begin
               acc        <= '0;
               mcand      <= {{WIDTH{arg1[M] & (op == OP_MULS)}}, arg1};
               mplier     <= arg2;
               count      <= CW'(WIDTH);
               mul_signed <= (op == OP_MULS);
            end else begin
               done <= 1'b1;
               if (!keep_result) result <= {{WIDTH{1'b0}}, alu_res};
            end
         end else if (state == MUL) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CW'(1);
            if (last_step) begin
               result <= acc_next;
               done   <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)                     sreg <= 8'h00;
      else if (sreg_write)           sreg <= sreg_wdata;
      else if (accept && !is_mul)    sreg <= alu_sreg;
      else if (last_step)            sreg <= mul_sreg;
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector self-checking bench for alu_seq (WIDTH=8).
module tb_alu_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic [3:0]  op;
   logic        use_carry;
   logic [7:0]  arg1;
   logic [7:0]  arg2;
   logic        sreg_write;
   logic [7:0]  sreg_wdata;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic [7:0]  sreg;

   int vectors_applied = 0;
   int miscompares     = 0;
   int done_cnt        = 0;
   int busy_cycles     = 0;

   alu_seq #(.WIDTH(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .op         (op),
      .use_carry  (use_carry),
      .arg1       (arg1),
      .arg2       (arg2),
      .sreg_write (sreg_write),
      .sreg_wdata (sreg_wdata),
      .busy       (busy),
      .done       (done),
      .result     (result),
      .sreg       (sreg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vectors_applied++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (done) done_cnt++;
   endtask

   task automatic applyStimulus(input logic [3:0] o, input logic uc, input logic [7:0] a, input logic [7:0] b);
      op        = o;
      use_carry = uc;
      arg1      = a;
      arg2      = b;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic writeSreg(input logic [7:0] val);
      sreg_write = 1'b1;
      sreg_wdata = val;
      tick();
      sreg_write = 1'b0;
   endtask

   // Waits out a multiply already accepted, counting cycles with busy high.
   task automatic waitMul();
      busy_cycles = 0;
      while (busy && busy_cycles < 50) begin
         busy_cycles++;
         tick();
      end
   endtask

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      op         = 4'd0;
      use_carry  = 1'b0;
      arg1       = 8'h00;
      arg2       = 8'h00;
      sreg_write = 1'b0;
      sreg_wdata = 8'h00;
      tick();
      tick();
      checkOutput("reset_result", 32'(result), 32'h0);
      checkOutput("reset_sreg", 32'(sreg), 32'h0);
      checkOutput("reset_busy", 32'(busy), 32'h0);
      checkOutput("reset_done", 32'(done), 32'h0);
      reset = 1'b0;
      tick();

      applyStimulus(4'd0, 1'b0, 8'h7F, 8'h01);
      checkOutput("add_done", 32'(done), 32'h1);
      checkOutput("add_result", 32'(result), 32'h0080);
      checkOutput("add_sreg", 32'(sreg), 32'h2C);
      tick();
      checkOutput("add_done_pulse", 32'(done), 32'h0);

      writeSreg(8'h00);
      checkOutput("sreg_write_clear", 32'(sreg), 32'h00);
      applyStimulus(4'd2, 1'b0, 8'hFF, 8'hFF);
      checkOutput("mul_busy_e0", 32'(busy), 32'h1);
      checkOutput("mul_no_early_done", 32'(done), 32'h0);
      waitMul();
      checkOutput("mul_busy_cycles", 32'(busy_cycles), 32'd8);
      checkOutput("mul_done", 32'(done), 32'h1);
      checkOutput("mul_result", 32'(result), 32'hFE01);
      checkOutput("mul_sreg", 32'(sreg), 32'h01);
      applyStimulus(4'd3, 1'b0, 8'hFF, 8'h02);
      waitMul();
      checkOutput("muls_result", 32'(result), 32'hFFFE);
      checkOutput("muls_sreg", 32'(sreg), 32'h01);
      applyStimulus(4'd3, 1'b0, 8'h02, 8'hFF);
      waitMul();
      checkOutput("muls_neg_mplier", 32'(result), 32'hFFFE);

      writeSreg(8'h03);
      applyStimulus(4'd1, 1'b1, 8'h00, 8'h00);
      checkOutput("sbc_result", 32'(result), 32'h00FF);
      checkOutput("sbc_sreg", 32'(sreg), 32'h35);
      writeSreg(8'h01);
      applyStimulus(4'd1, 1'b1, 8'h01, 8'h00);
      checkOutput("sbc_chain_result", 32'(result), 32'h0000);
      checkOutput("sbc_chain_z", 32'(sreg[1]), 32'h0);
      checkOutput("sbc_chain_sreg", 32'(sreg), 32'h00);

      applyStimulus(4'd6, 1'b0, 8'h81, 8'h00);
      checkOutput("asr_result", 32'(result), 32'h00C0);
      checkOutput("asr_sreg", 32'(sreg), 32'h15);
      applyStimulus(4'd4, 1'b1, 8'h88, 8'h00);
      checkOutput("rol_result", 32'(result), 32'h0011);
      checkOutput("rol_sreg", 32'(sreg), 32'h39);
      applyStimulus(4'd5, 1'b1, 8'h02, 8'h00);
      checkOutput("ror_result", 32'(result), 32'h0081);
      checkOutput("ror_sreg", 32'(sreg), 32'h2C);
      applyStimulus(4'd7, 1'b0, 8'hF0, 8'h0F);
      checkOutput("and_result", 32'(result), 32'h0000);
      checkOutput("and_sreg", 32'(sreg), 32'h22);
      applyStimulus(4'd9, 1'b0, 8'hAA, 8'h55);
      checkOutput("xor_result", 32'(result), 32'h00FF);
      checkOutput("xor_sreg", 32'(sreg), 32'h34);
      applyStimulus(4'd10, 1'b0, 8'h05, 8'h07);
      checkOutput("cp_result_kept", 32'(result), 32'h00FF);
      checkOutput("cp_sreg", 32'(sreg), 32'h35);
      applyStimulus(4'd12, 1'b0, 8'h12, 8'h34);
      checkOutput("rsvd_done", 32'(done), 32'h1);
      checkOutput("rsvd_result", 32'(result), 32'h0000);
      checkOutput("rsvd_sreg", 32'(sreg), 32'h35);
      applyStimulus(4'd0, 1'b1, 8'hFF, 8'h00);
      checkOutput("adc_result", 32'(result), 32'h0000);
      checkOutput("adc_sreg", 32'(sreg), 32'h23);

      writeSreg(8'h00);
      done_cnt = 0;
      applyStimulus(4'd2, 1'b0, 8'h03, 8'h05);
      tick();
      tick();
      applyStimulus(4'd0, 1'b0, 8'h01, 8'h01);
      for (int i = 0; i < 4; i++) tick();
      sreg_write = 1'b1;
      sreg_wdata = 8'hC0;
      tick();
      sreg_write = 1'b0;
      checkOutput("interlock_done", 32'(done), 32'h1);
      checkOutput("interlock_result", 32'(result), 32'h000F);
      checkOutput("interlock_sreg_wins", 32'(sreg), 32'hC0);
      for (int i = 0; i < 5; i++) tick();
      checkOutput("interlock_done_count", 32'(done_cnt), 32'd1);
      checkOutput("interlock_result_hold", 32'(result), 32'h000F);

      applyStimulus(4'd2, 1'b0, 8'hFF, 8'hFF);
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      checkOutput("abort_busy", 32'(busy), 32'h0);
      checkOutput("abort_done", 32'(done), 32'h0);
      checkOutput("abort_result", 32'(result), 32'h0);
      checkOutput("abort_sreg", 32'(sreg), 32'h0);
      done_cnt = 0;
      for (int i = 0; i < 10; i++) tick();
      checkOutput("abort_no_done", 32'(done_cnt), 32'd0);
      applyStimulus(4'd0, 1'b0, 8'h01, 8'h02);
      checkOutput("post_abort_done", 32'(done), 32'h1);
      checkOutput("post_abort_result", 32'(result), 32'h0003);
      checkOutput("post_abort_sreg", 32'(sreg), 32'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule
